// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg -- shared definitions for the 8-channel TDM serializer (tdm_mux8)
// and its matching receiver (tdm_demux8).
//
// Contents:
//   NUM_CH      number of TDM channels (slots per frame, excluding parity)
//   CNT_W       width of the slot counter / slot index
//   tdm_state_t frame FSM states; ST_PAR exists only when the parity slot
//               is built in (macro TDM_MUX8_PARITY_EN)
//   tdm_out_t   bundle of the registered serializer outputs
//   even_parity helper producing the even-parity bit of a frame
// -----------------------------------------------------------------------------
package tdm_pkg;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
`ifdef TDM_MUX8_PARITY_EN
    ,
    ST_PAR   = 2'd3
`endif
  } tdm_state_t;

  // Registered outputs kept together so they can be cleared, frozen and
  // updated as one unit.
  typedef struct packed {
    logic             y;
    logic [CNT_W-1:0] s;
    logic             frame;
    logic             busy;
    logic             done;
  } tdm_out_t;

  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [NUM_CH-1:0] v);
    return ^v;
  endfunction

endpackage : tdm_pkg

// File: rtl/tdm_slot_cnt.sv
// -----------------------------------------------------------------------------
// tdm_slot_cnt -- slot counter for the TDM serializer.
//
// Counts 0..NUM_CH-1 and wraps back to 0; it never holds a value above
// NUM_CH-1.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high reset (cnt -> 0)
//   en    in   advance the count by one this cycle
//   clr   in   force the count to 0 (wins over en)
//   cnt   out  current slot index
//   last  out  high while cnt is the final slot (NUM_CH-1)
// -----------------------------------------------------------------------------
module tdm_slot_cnt
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_CH - 1);

  assign last = (cnt == LAST_SLOT);

  // NOTE: state is updated with non-blocking assignments so every register
  // sampled at this edge sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      // Explicit wrap so the count stays bounded even if NUM_CH is not a
      // power of two.
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule : tdm_slot_cnt

// File: rtl/tdm_mux8.sv
// -----------------------------------------------------------------------------
// tdm_mux8 -- 8-channel time-division multiplexer (parallel-to-serial).
//
// On a load request in IDLE the eight channel bits are captured into a shadow
// register and sent one per cycle, channel 0 first. All outputs are
// registered: a load accepted at edge N shows slot 0 from edge N+1 and slot k
// from edge N+1+k. After the last slot a one-cycle done pulse is produced and
// the block returns to IDLE, where the next load can be accepted.
//
// Build option:
//   TDM_MUX8_PARITY_EN  when defined, a ninth slot carrying the even parity
//                       of the frame (s=7, frame=0, busy=1) follows slot 7.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset; beats load and en
//   en     in   global enable; low freezes all state and outputs
//   load   in   start a frame (honoured only in IDLE with en=1)
//   d      in   parallel channel data, d[i] = channel i
//   y      out  serialized TDM bit
//   s      out  index of the channel currently on y
//   frame  out  high during the slot-0 cycle
//   busy   out  high from the first slot through the last slot
//   done   out  one-cycle pulse after the last slot
// -----------------------------------------------------------------------------
module tdm_mux8
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [NUM_CH-1:0] d,
  output logic              y,
  output logic [CNT_W-1:0]  s,
  output logic              frame,
  output logic              busy,
  output logic              done
);

  tdm_state_t        state, state_nxt;
  tdm_out_t          out_q, out_nxt;
  logic [NUM_CH-1:0] shadow;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_last;
  logic              accept;
  logic              cnt_adv;

  // A frame is accepted only from IDLE; load elsewhere is dropped, not queued.
  assign accept  = en & load & (state == ST_IDLE);
  assign cnt_adv = en & (state == ST_SHIFT);

  tdm_slot_cnt u_slot_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_adv),
    .clr  (accept),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. The values computed here appear on the
  // outputs after the coming edge, which gives the one-cycle load-to-slot-0
  // latency.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    state_nxt = state;
    out_nxt   = '0;

    unique case (state)
      ST_IDLE: begin
        if (load) begin
          state_nxt = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        out_nxt.y     = shadow[cnt];
        out_nxt.s     = cnt;
        out_nxt.frame = (cnt == '0);
        out_nxt.busy  = 1'b1;
        if (cnt_last) begin
`ifdef TDM_MUX8_PARITY_EN
          state_nxt = ST_PAR;
`else
          state_nxt = ST_DONE;
`endif
        end
      end

`ifdef TDM_MUX8_PARITY_EN
      ST_PAR: begin
        out_nxt.y    = even_parity(shadow);
        out_nxt.s    = CNT_W'(NUM_CH - 1);
        out_nxt.busy = 1'b1;
        state_nxt    = ST_DONE;
      end
`endif

      ST_DONE: begin
        out_nxt.done = 1'b1;
        state_nxt    = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, shadow and output registers. With en low nothing moves, so a
  // frozen done pulse is neither lost nor repeated.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      out_q  <= '0;
      // NOTE: the shadow register is reset too, so a frame abandoned by rst
      // leaves no stale channel data behind.
      shadow <= '0;
    end else if (en) begin
      state <= state_nxt;
      out_q <= out_nxt;
      if (accept) begin
        shadow <= d;
      end
    end
  end

  assign y     = out_q.y;
  assign s     = out_q.s;
  assign frame = out_q.frame;
  assign busy  = out_q.busy;
  assign done  = out_q.done;

endmodule : tdm_mux8
